// File: rtl/reg_file_scoreboard_pkg.sv
// Shared SimpleRISC register-file constants and types.
package simplerisc_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [NUM_REGS-1:0] busy_t;

    localparam addr_t REG_RA = 4'd15;
    localparam addr_t REG_SP = 4'd14;

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Operand-fetch / write-back bus into the register file and scoreboard.
interface reg_file_scoreboard_if import simplerisc_pkg::*; ();

    addr_t rd_addr1;
    addr_t rd_addr2;
    data_t rd_data1;
    data_t rd_data2;
    logic  write_en;
    addr_t write_addr;
    data_t write_data;
    logic  issue_valid;
    logic  issue_use1;
    logic  issue_use2;
    logic  issue_wb;
    addr_t issue_dest;
    logic  stall;
    busy_t busy;

    modport master (
        output rd_addr1, rd_addr2, write_en, write_addr, write_data,
        output issue_valid, issue_use1, issue_use2, issue_wb, issue_dest,
        input  rd_data1, rd_data2, stall, busy
    );

    modport slave (
        input  rd_addr1, rd_addr2, write_en, write_addr, write_data,
        input  issue_valid, issue_use1, issue_use2, issue_wb, issue_dest,
        output rd_data1, rd_data2, stall, busy
    );

endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// Pending-write scoreboard: busy vector and RAW/WAW stall generation.
module reg_scoreboard import simplerisc_pkg::*; (
    input  logic  clk,
    input  logic  reset,
    input  logic  write_en,
    input  addr_t write_addr,
    input  addr_t rd_addr1,
    input  addr_t rd_addr2,
    input  logic  issue_valid,
    input  logic  issue_use1,
    input  logic  issue_use2,
    input  logic  issue_wb,
    input  addr_t issue_dest,
    output logic  stall,
    output busy_t busy
);

    busy_t busy_q;
    busy_t busy_d;
    logic  src_haz1;
    logic  src_haz2;
    logic  waw;
    logic  accept;

    always_comb begin
        // A write-back landing this cycle resolves the hazard on its index.
        src_haz1 = issue_use1 && busy_q[rd_addr1] && !(write_en && (write_addr == rd_addr1));
        src_haz2 = issue_use2 && busy_q[rd_addr2] && !(write_en && (write_addr == rd_addr2));
        waw      = issue_wb && busy_q[issue_dest] && !(write_en && (write_addr == issue_dest));
        stall    = issue_valid && (src_haz1 || src_haz2 || waw);
        accept   = issue_valid && !stall;

        busy_d = busy_q;
        if (write_en) begin
            busy_d[write_addr] = 1'b0;
        end
        if (accept && issue_wb) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with write-to-read bypass and pending-write scoreboard.
module reg_file_scoreboard import simplerisc_pkg::*; (
    input logic                  clk,
    input logic                  reset,
    reg_file_scoreboard_if.slave bus
);

    data_t regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else if (bus.write_en) begin
            regs_q[bus.write_addr] <= bus.write_data;
        end
    end

    always_comb begin
        bus.rd_data1 = regs_q[bus.rd_addr1];
        bus.rd_data2 = regs_q[bus.rd_addr2];
        if (bus.write_en && (bus.write_addr == bus.rd_addr1)) begin
            bus.rd_data1 = bus.write_data;
        end
        if (bus.write_en && (bus.write_addr == bus.rd_addr2)) begin
            bus.rd_data2 = bus.write_data;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .write_en    (bus.write_en),
        .write_addr  (bus.write_addr),
        .rd_addr1    (bus.rd_addr1),
        .rd_addr2    (bus.rd_addr2),
        .issue_valid (bus.issue_valid),
        .issue_use1  (bus.issue_use1),
        .issue_use2  (bus.issue_use2),
        .issue_wb    (bus.issue_wb),
        .issue_dest  (bus.issue_dest),
        .stall       (bus.stall),
        .busy        (bus.busy)
    );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard against an array-based reference model.
module tb_reg_file_scoreboard;
    import simplerisc_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] m_regs [16];
    bit          m_busy [16];

    reg_file_scoreboard_if bus ();

    reg_file_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (bus.write_en && bus.write_addr == a) return bus.write_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_stall();
        bit h1, h2, w;
        h1 = bus.issue_use1 && m_busy[bus.rd_addr1]
             && !(bus.write_en && bus.write_addr == bus.rd_addr1);
        h2 = bus.issue_use2 && m_busy[bus.rd_addr2]
             && !(bus.write_en && bus.write_addr == bus.rd_addr2);
        w  = bus.issue_wb && m_busy[bus.issue_dest]
             && !(bus.write_en && bus.write_addr == bus.issue_dest);
        return bus.issue_valid && (h1 || h2 || w);
    endfunction

    function automatic logic [15:0] exp_busy();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        bit acc;
        acc = bus.issue_valid && !exp_stall();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (bus.write_en) begin
                m_regs[bus.write_addr] = bus.write_data;
                m_busy[bus.write_addr] = 1'b0;
            end
            if (acc && bus.issue_wb) m_busy[bus.issue_dest] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        bus.write_en    = 1'b0;
        bus.write_addr  = '0;
        bus.write_data  = '0;
        bus.issue_valid = 1'b0;
        bus.issue_use1  = 1'b0;
        bus.issue_use2  = 1'b0;
        bus.issue_wb    = 1'b0;
        bus.issue_dest  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr1 = 4'(i);
            bus.rd_addr2 = 4'(15 - i);
            #1;
            n_checks += 2;
            if (bus.rd_data1 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd1[%0d] got=%h exp=0", i, bus.rd_data1);
            end
            if (bus.rd_data2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd2[%0d] got=%h exp=0", 15 - i, bus.rd_data2);
            end
        end
        n_checks += 2;
        if (bus.busy !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_busy got=%h exp=0", bus.busy);
        end
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.write_en   = 1'b1;
        bus.write_addr = 4'd3;
        bus.write_data = 32'hDEADBEEF;
        bus.rd_addr1   = 4'd3;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_rd1 got=%h exp=deadbeef", bus.rd_data1);
        end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.rd_data1 !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL stored_rd1 cyc=%0d got=%h exp=deadbeef", c, bus.rd_data1);
            end
            tick();
        end
    endtask

    task automatic test_raw();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_wb    = 1'b1;
        bus.issue_dest  = 4'd5;
        tick();
        bus.issue_wb   = 1'b0;
        bus.issue_use1 = 1'b1;
        bus.rd_addr1   = 4'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.stall !== 1'b1) begin
                n_fail++;
                $display("FAIL raw_stall cyc=%0d got=%b exp=1", c, bus.stall);
            end
            tick();
        end
        bus.write_en   = 1'b1;
        bus.write_addr = 4'd5;
        bus.write_data = 32'h1234_5678;
        #1;
        n_checks += 2;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_release_stall got=%b exp=0", bus.stall);
        end
        if (bus.rd_data1 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL raw_release_rd1 got=%h exp=12345678", bus.rd_data1);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_busy5 got=%b exp=0", bus.busy[5]);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        bus.write_en    = 1'b1;
        bus.write_addr  = 4'd7;
        bus.write_data  = 32'hA5A5_0007;
        bus.issue_valid = 1'b1;
        bus.issue_wb    = 1'b1;
        bus.issue_dest  = 4'd7;
        tick();
        idle();
        bus.rd_addr1 = 4'd7;
        #1;
        n_checks += 2;
        if (bus.busy[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL setwins_busy7 got=%b exp=1", bus.busy[7]);
        end
        if (bus.rd_data1 !== 32'hA5A5_0007) begin
            n_fail++;
            $display("FAIL setwins_reg7 got=%h exp=a5a50007", bus.rd_data1);
        end
    endtask

    task automatic test_call();
        idle();
        bus.write_en   = 1'b1;
        bus.write_addr = REG_RA;
        bus.write_data = 32'h104;
        bus.rd_addr2   = REG_RA;
        #1;
        n_checks++;
        if (bus.rd_data2 !== 32'h104) begin
            n_fail++;
            $display("FAIL call_rd2 got=%h exp=104", bus.rd_data2);
        end
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_wb    = 1'b1;
        bus.issue_dest  = REG_RA;
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL call_first_issue_stall got=%b exp=0", bus.stall);
        end
        tick();
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_stall got=%b exp=1", bus.stall);
        end
        idle();
        bus.write_en   = 1'b1;
        bus.write_addr = REG_RA;
        bus.write_data = 32'h200;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_wb    = 1'b1;
        bus.issue_dest  = 4'd2;
        tick();
        bus.issue_dest = 4'd9;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy !== exp_busy() || bus.busy[2] !== 1'b1 || bus.busy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy got=%h exp=%h", bus.busy, exp_busy());
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_use1  = 1'b1;
        bus.rd_addr1    = 4'd2;
        bus.rd_addr2    = 4'd3;
        #1;
        n_checks += 4;
        if (bus.busy !== 16'h0) begin
            n_fail++;
            $display("FAIL post_reset_busy got=%h exp=0", bus.busy);
        end
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_stall got=%b exp=0", bus.stall);
        end
        if (bus.rd_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_r2 got=%h exp=0", bus.rd_data1);
        end
        if (bus.rd_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_r3 got=%h exp=0", bus.rd_data2);
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset           = ($urandom_range(0, 63) == 0);
            bus.write_en    = $urandom_range(0, 1);
            bus.write_addr  = 4'($urandom_range(0, 15));
            bus.write_data  = $urandom;
            bus.rd_addr1    = 4'($urandom_range(0, 15));
            bus.rd_addr2    = 4'($urandom_range(0, 15));
            bus.issue_valid = ($urandom_range(0, 3) != 0);
            bus.issue_use1  = $urandom_range(0, 1);
            bus.issue_use2  = $urandom_range(0, 1);
            bus.issue_wb    = $urandom_range(0, 1);
            bus.issue_dest  = 4'($urandom_range(0, 15));
            #1;
            n_checks += 4;
            if (bus.rd_data1 !== exp_rd(bus.rd_addr1)) begin
                n_fail++;
                $display("FAIL rand_rd1 cyc=%0d got=%h exp=%h", c, bus.rd_data1,
                         exp_rd(bus.rd_addr1));
            end
            if (bus.rd_data2 !== exp_rd(bus.rd_addr2)) begin
                n_fail++;
                $display("FAIL rand_rd2 cyc=%0d got=%h exp=%h", c, bus.rd_data2,
                         exp_rd(bus.rd_addr2));
            end
            if (bus.stall !== exp_stall()) begin
                n_fail++;
                $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, bus.stall, exp_stall());
            end
            if (bus.busy !== exp_busy()) begin
                n_fail++;
                $display("FAIL rand_busy cyc=%0d got=%h exp=%h", c, bus.busy, exp_busy());
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        idle();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        #2;
        test_reset();
        test_bypass();
        test_raw();
        test_same_cycle();
        test_call();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
